// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary pointer conversion.
// Values narrower than GRAY_MAX_W are zero-extended on entry and truncated on exit.
package fifo_pkg;

   localparam int GRAY_MAX_W = 16;

   typedef logic [GRAY_MAX_W-1:0] gvec_t;

   function automatic gvec_t bin2gray(input gvec_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Leading zero bits XOR to nothing, so a zero-extended pointer converts exactly.
   function automatic gvec_t gray2bin(input gvec_t gray);
      gvec_t bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Plain flop chain, no logic between stages; all stages clear on aclr.
module gray_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic [WIDTH-1:0] async_d,
   output logic [WIDTH-1:0] sync_q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Shift the asynchronous pointer through the synchroniser chain.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= async_d;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign sync_q = stage_r[STAGES-1];

endmodule

// File: rtl/rd_ctrl_sync.sv
// Read-domain controller of the dual-clock FIFO: read pointer, synced write pointer, empty/usedw flags.
// Optional sticky underflow flag built when RD_UNDERFLOW_CHK_EN is defined.
module rd_ctrl_sync
   import fifo_pkg::*;
#(
   parameter int AWIDTH      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AEMPTY_THR  = 1
) (
   input  logic              rd_clk_i,
   input  logic              aclr_i,
   input  logic              rd_req_i,
   input  logic [AWIDTH:0]   wr_pntr_gray_i,
   output logic [AWIDTH-1:0] rd_pntr_o,
   output logic [AWIDTH:0]   rd_pntr_gray_o,
   output logic              rd_empty_o,
   output logic              rd_almost_empty_o,
   output logic [AWIDTH:0]   rd_usedw_o,
   output logic              rd_underflow_o
);

   localparam int PTR_W = AWIDTH + 1;
   localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AEMPTY_THR);

   logic [PTR_W-1:0] wr_gray_s;
   logic [PTR_W-1:0] wr_bin_s;
   logic [PTR_W-1:0] rd_bin_r;
   logic [PTR_W-1:0] rd_bin_nxt_s;
   logic [PTR_W-1:0] rd_gray_nxt_s;
   logic [PTR_W-1:0] usedw_nxt_s;
   logic             rd_acc_s;

   gray_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wr_sync (
      .clk     (rd_clk_i),
      .aclr    (aclr_i),
      .async_d (wr_pntr_gray_i),
      .sync_q  (wr_gray_s)
   );

   // Next read pointer and fill count; the MSB keeps a full FIFO distinct from an empty one.
   always_comb begin
      rd_acc_s      = rd_req_i & ~rd_empty_o;
      rd_bin_nxt_s  = rd_bin_r + {{AWIDTH{1'b0}}, rd_acc_s};
      rd_gray_nxt_s = PTR_W'(bin2gray(gvec_t'(rd_bin_nxt_s)));
      wr_bin_s      = PTR_W'(gray2bin(gvec_t'(wr_gray_s)));
      usedw_nxt_s   = wr_bin_s - rd_bin_nxt_s;
   end

   // Pointer and flag registers, all updated on the same edge.
   always_ff @(posedge rd_clk_i or posedge aclr_i) begin
      if (aclr_i) begin
         rd_bin_r          <= {PTR_W{1'b0}};
         rd_pntr_gray_o    <= {PTR_W{1'b0}};
         rd_empty_o        <= 1'b1;
         rd_almost_empty_o <= 1'b1;
         rd_usedw_o        <= {PTR_W{1'b0}};
      end else begin
         rd_bin_r          <= rd_bin_nxt_s;
         rd_pntr_gray_o    <= rd_gray_nxt_s;
         rd_empty_o        <= (rd_gray_nxt_s == wr_gray_s);
         rd_almost_empty_o <= (usedw_nxt_s <= AE_THR);
         rd_usedw_o        <= usedw_nxt_s;
      end
   end

   assign rd_pntr_o = rd_bin_r[AWIDTH-1:0];

`ifdef RD_UNDERFLOW_CHK_EN
   logic rd_underflow_r;

   // Sticky record of any read attempted while empty; only aclr_i clears it.
   always_ff @(posedge rd_clk_i or posedge aclr_i) begin
      if (aclr_i) begin
         rd_underflow_r <= 1'b0;
      end else if (rd_req_i & rd_empty_o) begin
         rd_underflow_r <= 1'b1;
      end else begin
         rd_underflow_r <= rd_underflow_r;
      end
   end

   assign rd_underflow_o = rd_underflow_r;
`else
   assign rd_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ctrl_sync.sv
// Scoreboard bench for rd_ctrl_sync: integer read/write counts model the FIFO, a monitor compares each edge.
module tb_rd_ctrl_sync;

   localparam int AW = 3;
   localparam int SS = 2;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] pntr;
      logic [AW:0]   gray;
      logic          empty;
      logic          aempty;
      logic [AW:0]   usedw;
      logic          uf;
   } exp_t;

   logic          rd_clk_i = 1'b0;
   logic          aclr_i   = 1'b1;
   logic          rd_req_i = 1'b0;
   logic [AW:0]   wr_pntr_gray_i = '0;
   logic [AW-1:0] rd_pntr_o;
   logic [AW:0]   rd_pntr_gray_o;
   logic          rd_empty_o;
   logic          rd_almost_empty_o;
   logic [AW:0]   rd_usedw_o;
   logic          rd_underflow_o;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   // reference model state
   int   rd_cnt, wr_cnt;
   int   hist [SS+1];
   bit   m_empty, m_uf;
   int   m_used;

   rd_ctrl_sync #(.AWIDTH(AW), .SYNC_STAGES(SS), .AEMPTY_THR(1)) dut (
      .rd_clk_i          (rd_clk_i),
      .aclr_i            (aclr_i),
      .rd_req_i          (rd_req_i),
      .wr_pntr_gray_i    (wr_pntr_gray_i),
      .rd_pntr_o         (rd_pntr_o),
      .rd_pntr_gray_o    (rd_pntr_gray_o),
      .rd_empty_o        (rd_empty_o),
      .rd_almost_empty_o (rd_almost_empty_o),
      .rd_usedw_o        (rd_usedw_o),
      .rd_underflow_o    (rd_underflow_o)
   );

   always #5 rd_clk_i = ~rd_clk_i;

   function automatic logic [AW:0] to_gray(input int n);
      logic [AW:0] b;
      b = AW'(0) + (AW+1)'(n % (2 * DEPTH));
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      rd_cnt = 0;
      wr_cnt = 0;
      for (int i = 0; i <= SS; i++) hist[i] = 0;
      m_empty = 1'b1;
      m_uf    = 1'b0;
      m_used  = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pntr"},   int'(rd_pntr_o), 0);
      check({tag, "_gray"},   int'(rd_pntr_gray_o), 0);
      check({tag, "_empty"},  int'(rd_empty_o), 1);
      check({tag, "_aempty"}, int'(rd_almost_empty_o), 1);
      check({tag, "_usedw"},  int'(rd_usedw_o), 0);
      check({tag, "_uf"},     int'(rd_underflow_o), 0);
   endtask

   // One read-clock cycle: drive inputs at the falling edge and queue the expected post-edge state.
   task automatic step(input bit req, input int wr_target);
      exp_t e;
      bit   acc;
      @(negedge rd_clk_i);
      wr_cnt         = wr_target;
      rd_req_i       = req;
      wr_pntr_gray_i = to_gray(wr_cnt);
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wr_cnt;
      acc = req && !m_empty;
`ifdef RD_UNDERFLOW_CHK_EN
      if (req && m_empty) m_uf = 1'b1;
`endif
      if (acc) rd_cnt++;
      m_used  = (hist[SS] - rd_cnt) % (2 * DEPTH);
      if (m_used < 0) m_used += 2 * DEPTH;
      m_empty = (m_used == 0);
      e.pntr   = AW'(rd_cnt % DEPTH);
      e.gray   = to_gray(rd_cnt);
      e.empty  = m_empty;
      e.aempty = (m_used <= 1);
      e.usedw  = (AW+1)'(m_used);
      e.uf     = m_uf;
      exp_q.push_back(e);
   endtask

   // Monitor: after every rising edge, compare the DUT against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge rd_clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_pntr",      int'(rd_pntr_o), int'(e.pntr));
            check("rd_pntr_gray", int'(rd_pntr_gray_o), int'(e.gray));
            check("empty",        int'(rd_empty_o), int'(e.empty));
            check("almost_empty", int'(rd_almost_empty_o), int'(e.aempty));
            check("usedw",        int'(rd_usedw_o), int'(e.usedw));
            check("underflow",    int'(rd_underflow_o), int'(e.uf));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int rd_pct, wr_pct;
      bit req;
      int w;
      model_reset();
      #23;
      check_reset_outputs("reset");
      @(negedge rd_clk_i);
      aclr_i = 1'b0;

      // release with requests pending on an empty FIFO
      for (int i = 0; i < 4; i++) step(1'b0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 0);
      // single word written
      for (int i = 0; i < 4; i++) step(1'b0, 1);
      // jump to full, then drain eight words and try once more
      for (int i = 0; i < 4; i++) step(1'b0, 8);
      for (int i = 0; i < 9; i++) step(1'b1, 8);
      // across the pointer wrap
      for (int i = 0; i < 4; i++) step(1'b0, 9);
      step(1'b1, 9);
      for (int i = 0; i < 2; i++) step(1'b0, 9);
      // underflow pulse then idle
      step(1'b1, 9);
      for (int i = 0; i < 3; i++) step(1'b0, 9);

      // randomized traffic in bursts of varying read/write intensity
      for (int blk = 0; blk < 16; blk++) begin
         rd_pct = $urandom_range(10, 90);
         wr_pct = $urandom_range(10, 90);
         for (int i = 0; i < 100; i++) begin
            req = ($urandom_range(0, 99) < rd_pct);
            w   = wr_cnt;
            if (($urandom_range(0, 99) < wr_pct) && (w - rd_cnt < DEPTH)) w++;
            step(req, w);
         end
      end

      // asynchronous clear in the middle of a read burst
      for (int i = 0; i < 4; i++) step(1'b0, wr_cnt + 5 - (wr_cnt - rd_cnt));
      step(1'b1, wr_cnt);
      step(1'b1, wr_cnt);
      @(posedge rd_clk_i);
      #3;
      check("pre_clear_usedw", int'(rd_usedw_o), m_used);
      aclr_i = 1'b1;
      wr_pntr_gray_i = '0;
      rd_req_i = 1'b1;
      #1;
      check_reset_outputs("async_clear");
      model_reset();
      @(negedge rd_clk_i);
      @(negedge rd_clk_i);
      aclr_i = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 0);
      for (int i = 0; i < 5; i++) step(1'b0, 2);
      for (int i = 0; i < 3; i++) step(1'b1, 2);

      @(posedge rd_clk_i);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
